// File: rtl/ram_scan_reader_pkg.sv
// Shared types and defaults for the RAM scan reader: FSM state encoding,
// default geometry and the wait-counter load helper.
package ram_scan_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 3;
  localparam int DEF_TICK_DIV = 50_000_000;
  localparam int DEF_RD_LAT   = 1;

  // Wide enough for RD_LAT-1 with RD_LAT in {1,2}.
  localparam int WAIT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } scan_state_t;

  // Cycles still to wait after leaving IDLE before ram_q holds the word.
  function automatic logic [WAIT_W-1:0] wait_load(input int rd_lat);
    return WAIT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/ram_scan_reader_if.sv
// RAM read port plus the valid/ready presentation port of the scan reader.
// master = the reader; slave = RAM + downstream consumer.
interface ram_scan_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
);

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_addr,
    output out_addr,
    output out_data,
    output out_valid,
    input  ram_q,
    input  out_ready
  );

  modport slave (
    input  rd_addr,
    input  out_addr,
    input  out_data,
    input  out_valid,
    output ram_q,
    output out_ready
  );

endinterface

// File: rtl/ram_scan_reader_tick_divider.sv
// Run-gated modulo-TICK_DIV counter; o_tick pulses for one cycle on the
// terminal count while running.
module tick_divider
  import ram_scan_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_run & w_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_scan_reader.sv
// Handshaked read engine for the dual-port RAM: steps rd_addr on a tick or a
// step edge, waits out the RAM read latency and presents {addr, data}.
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                step,
  input  logic                restart,
  ram_scan_reader_if.master   bus,
  output logic                overrun
);

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_pending;
  logic              r_overrun;
  logic              r_step_q;

  logic w_tick;
  logic w_step_rise;
  logic w_req;
  logic w_accept;
  logic w_drop;
  logic w_leave_idle;
  logic w_capture;
  logic w_handshake;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_run   (run),
    .i_clr   (restart),
    .o_tick  (w_tick)
  );

  // A tick and a step edge together are a single request; only an idle
  // engine with nothing pending may accept it.
  assign w_step_rise = step & ~r_step_q;
  assign w_req       = w_tick | w_step_rise;
  assign w_accept    = w_req & ~r_pending & (r_state == IDLE);
  assign w_drop      = w_req & ~w_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_leave_idle = 1'b0;
    w_capture    = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_state_nxt  = WAIT;
          w_leave_idle = 1'b1;
        end
      end
      WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = PRESENT;
          w_capture   = 1'b1;
        end
      end
      PRESENT: begin
        if (r_out_valid && bus.out_ready) begin
          w_state_nxt = IDLE;
          w_handshake = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (restart) begin
      w_state_nxt  = IDLE;
      w_leave_idle = 1'b0;
      w_capture    = 1'b0;
      w_handshake  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (w_leave_idle) begin
      r_wait_cnt <= wait_load(RD_LAT);
    end else if (r_state == WAIT && r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  // The step history tracks the level even across restart, so a key held
  // through a restart does not fire a second request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (restart) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_leave_idle) begin
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // rd_addr only moves on a handshake or restart, so it is stable for the
  // whole of any read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
    end else if (restart) begin
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
      r_rd_addr   <= r_rd_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_addr <= '0;
      r_out_data <= '0;
    end else if (w_capture) begin
      r_out_addr <= r_rd_addr;
      r_out_data <= bus.ram_q;
    end
  end

  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Self-checking bench for ram_scan_reader: RD_LAT=1 and RD_LAT=2 instances,
// scoreboard of presented words against the RAM contents.
module tb_ram_scan_reader;
  import ram_scan_pkg::*;

  localparam int AW = 5;
  localparam int DW = 3;
  localparam int TD = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // ---------------- instance 1: RD_LAT = 1 ----------------
  logic reset_n, run, step, restart, overrun;
  ram_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  logic [DW-1:0] mem1 [DEPTH];

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .restart(restart),
    .bus(bus1.master), .overrun(overrun)
  );

  always @(posedge clk) bus1.ram_q <= mem1[bus1.rd_addr];

  // ---------------- instance 2: RD_LAT = 2 ----------------
  logic reset_n2, run2, step2, restart2, overrun2;
  ram_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
  logic [DW-1:0] mem2 [DEPTH];
  logic [DW-1:0] q2_stage;

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD), .RD_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n2), .run(run2), .step(step2), .restart(restart2),
    .bus(bus2.master), .overrun(overrun2)
  );

  always @(posedge clk) begin
    q2_stage   <= mem2[bus2.rd_addr];
    bus2.ram_q <= q2_stage;
  end

  // Words seen by step_watch, packed {addr, data}.
  logic [AW+DW-1:0] q_words [$];
  logic             seen_valid = 1'b0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives step to lvl for n cycles and collects every newly presented word.
  task automatic step_watch(input int n, input logic lvl);
    step = lvl;
    repeat (n) begin
      @(negedge clk);
      if (bus1.out_valid && !seen_valid) q_words.push_back({bus1.out_addr, bus1.out_data});
      seen_valid = bus1.out_valid;
    end
  endtask

  function automatic logic [DW-1:0] word1(input logic [AW-1:0] a);
    return DW'(a % 8);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; step = 1'b0; restart = 1'b0; bus1.out_ready = 1'b1;
    reset_n2 = 1'b0; run2 = 1'b0; step2 = 1'b0; restart2 = 1'b0; bus2.out_ready = 1'b1;
    cyc(3);
    n_run++; if (bus1.rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", bus1.rd_addr); end
    n_run++; if (bus1.out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr got %0d want 0", bus1.out_addr); end
    n_run++; if (bus1.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", bus1.out_data); end
    n_run++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus1.out_valid); end
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_autoscan();
    int lat;
    int gap;
    logic [AW-1:0] exp_addr;
    run = 1'b1; bus1.out_ready = 1'b1; reset_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (bus1.out_valid) begin lat = i; break; end
    end
    n_run++; if (lat != 6) begin n_fail++; $display("FAIL auto_first_latency got %0d want 6", lat); end
    exp_addr = '0;
    for (int w = 0; w < 34; w++) begin
      if (w > 0) begin
        gap = 0;
        for (int k = 1; k <= 10; k++) begin
          cyc(1);
          if (bus1.out_valid) begin gap = k; break; end
        end
        n_run++; if (gap != 4) begin n_fail++; $display("FAIL auto_interval w=%0d got %0d want 4", w, gap); end
      end
      n_run++; if (bus1.out_addr !== exp_addr) begin n_fail++; $display("FAIL auto_addr got %0d want %0d", bus1.out_addr, exp_addr); end
      n_run++; if (bus1.out_data !== word1(exp_addr)) begin n_fail++; $display("FAIL auto_data a=%0d got %0d want %0d", exp_addr, bus1.out_data, word1(exp_addr)); end
      exp_addr = exp_addr + 1'b1;
    end
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL auto_overrun got %b want 0", overrun); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] h_addr, h_rd, exp_next, p_addr;
    logic [DW-1:0] h_data, p_data;
    logic p_valid, p_ready;
    // A word is on the port right now; stall it.
    bus1.out_ready = 1'b0;
    h_addr = bus1.out_addr; h_data = bus1.out_data; h_rd = bus1.rd_addr;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_run++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d got %b want 1", i, bus1.out_valid); end
      n_run++; if (bus1.out_addr !== h_addr || bus1.out_data !== h_data) begin
        n_fail++; $display("FAIL bp_hold c=%0d got %0d/%0d want %0d/%0d", i, bus1.out_addr, bus1.out_data, h_addr, h_data); end
      n_run++; if (bus1.rd_addr !== h_rd) begin n_fail++; $display("FAIL bp_rd_addr c=%0d got %0d want %0d", i, bus1.rd_addr, h_rd); end
    end
    n_run++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b want 1", overrun); end
    bus1.out_ready = 1'b1;
    cyc(1);
    n_run++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", bus1.out_valid); end
    n_run++; if (bus1.rd_addr !== h_rd + 1'b1) begin n_fail++; $display("FAIL bp_release_rd got %0d want %0d", bus1.rd_addr, h_rd + 1'b1); end

    // Random backpressure: words are consecutive, stalled words never change.
    exp_next = h_addr + 1'b1;
    p_valid = 1'b0; p_ready = 1'b1; p_addr = '0; p_data = '0;
    for (int c = 0; c < 300; c++) begin
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      p_ready = bus1.out_ready;
      cyc(1);
      if (p_valid && !p_ready) begin
        n_run++; if (bus1.out_valid !== 1'b1 || bus1.out_addr !== p_addr || bus1.out_data !== p_data) begin
          n_fail++; $display("FAIL rbp_stall_hold got v=%b %0d/%0d want v=1 %0d/%0d", bus1.out_valid, bus1.out_addr, bus1.out_data, p_addr, p_data); end
      end else if (bus1.out_valid) begin
        n_run++; if (bus1.out_addr !== exp_next || bus1.out_data !== word1(exp_next)) begin
          n_fail++; $display("FAIL rbp_word got %0d/%0d want %0d/%0d", bus1.out_addr, bus1.out_data, exp_next, word1(exp_next)); end
        exp_next = exp_next + 1'b1;
      end
      p_valid = bus1.out_valid; p_addr = bus1.out_addr; p_data = bus1.out_data;
    end
    bus1.out_ready = 1'b1;
  endtask

  task automatic test_step();
    logic [AW-1:0] exp_addr;
    int            n_pulses;
    run = 1'b0; restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    cyc(2);
    q_words.delete(); seen_valid = bus1.out_valid;
    step_watch(5, 1'b1);
    step_watch(4, 1'b0);
    step_watch(5, 1'b1);
    step_watch(6, 1'b0);
    n_run++; if (q_words.size() != 2) begin n_fail++; $display("FAIL step_count got %0d want 2", q_words.size()); end
    else begin
      n_run++; if (q_words[0] !== {5'd0, word1(5'd0)}) begin n_fail++; $display("FAIL step_word0 got %h want %h", q_words[0], {5'd0, word1(5'd0)}); end
      n_run++; if (q_words[1] !== {5'd1, word1(5'd1)}) begin n_fail++; $display("FAIL step_word1 got %h want %h", q_words[1], {5'd1, word1(5'd1)}); end
    end
    n_run++; if (dut.u_tick.r_cnt !== '0) begin n_fail++; $display("FAIL step_tick_frozen got %0d want 0", dut.u_tick.r_cnt); end

    // Random step pulses, spaced far enough apart that none is dropped.
    q_words.delete();
    n_pulses = 8;
    for (int p = 0; p < n_pulses; p++) begin
      step_watch($urandom_range(1, 5), 1'b1);
      step_watch($urandom_range(6, 10), 1'b0);
    end
    n_run++; if (q_words.size() != n_pulses) begin n_fail++; $display("FAIL rstep_count got %0d want %0d", q_words.size(), n_pulses); end
    exp_addr = 5'd2;
    foreach (q_words[i]) begin
      n_run++; if (q_words[i] !== {exp_addr, word1(exp_addr)}) begin
        n_fail++; $display("FAIL rstep_word i=%0d got %h want %h", i, q_words[i], {exp_addr, word1(exp_addr)}); end
      exp_addr = exp_addr + 1'b1;
    end
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstep_overrun got %b want 0", overrun); end
  endtask

  task automatic test_restart();
    int lat;
    run = 1'b0; restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    q_words.delete(); seen_valid = bus1.out_valid;
    for (int i = 0; i < 9; i++) begin
      step_watch(1, 1'b1);
      step_watch(5, 1'b0);
    end
    n_run++; if (q_words.size() != 9) begin n_fail++; $display("FAIL rst_pre_count got %0d want 9", q_words.size()); end
    bus1.out_ready = 1'b0;
    step_watch(1, 1'b1);
    step_watch(4, 1'b0);
    n_run++; if (bus1.out_valid !== 1'b1 || bus1.out_addr !== 5'd9) begin
      n_fail++; $display("FAIL rst_present9 got v=%b a=%0d want v=1 a=9", bus1.out_valid, bus1.out_addr); end
    step_watch(1, 1'b1);
    step_watch(1, 1'b0);
    n_run++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL rst_pre_overrun got %b want 1", overrun); end
    run = 1'b1;
    cyc(3);
    n_run++; if (dut.w_tick !== 1'b1) begin n_fail++; $display("FAIL rst_tick_align got %b want 1", dut.w_tick); end
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    n_run++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus1.out_valid); end
    n_run++; if (bus1.rd_addr !== '0) begin n_fail++; $display("FAIL rst_rd_addr got %0d want 0", bus1.rd_addr); end
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", overrun); end
    bus1.out_ready = 1'b1;
    lat = 0;
    for (int i = 2; i <= 14; i++) begin
      cyc(1);
      if (bus1.out_valid) begin lat = i; break; end
    end
    n_run++; if (lat != 7) begin n_fail++; $display("FAIL rst_next_latency got %0d want 7", lat); end
    n_run++; if (bus1.out_addr !== '0 || bus1.out_data !== '0) begin
      n_fail++; $display("FAIL rst_next_word got %0d/%0d want 0/0", bus1.out_addr, bus1.out_data); end
  endtask

  task automatic test_async_reset();
    int   lat;
    logic saw_valid;
    run = 1'b0;
    cyc(8);
    seen_valid = bus1.out_valid;
    step_watch(1, 1'b1);
    step_watch(1, 1'b0);
    step_watch(1, 1'b1);
    step_watch(6, 1'b0);
    n_run++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ar_pre_overrun got %b want 1", overrun); end
    step = 1'b1;
    cyc(2);
    n_run++; if (bus1.out_valid !== 1'b0 || dut.r_state !== WAIT) begin
      n_fail++; $display("FAIL ar_pre_wait got v=%b s=%0d want v=0 s=%0d", bus1.out_valid, dut.r_state, WAIT); end
    #3 reset_n = 1'b0;
    #1;
    n_run++; if ({bus1.rd_addr, bus1.out_addr, bus1.out_data, bus1.out_valid, overrun} !== '0) begin
      n_fail++; $display("FAIL ar_outputs got rd=%0d a=%0d d=%0d v=%b o=%b want all 0",
                         bus1.rd_addr, bus1.out_addr, bus1.out_data, bus1.out_valid, overrun); end
    step = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (bus1.out_valid) saw_valid = 1'b1;
    end
    n_run++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL ar_no_spurious got %b want 0", saw_valid); end
    step = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (bus1.out_valid) begin lat = i; break; end
    end
    step = 1'b0;
    n_run++; if (lat != 3) begin n_fail++; $display("FAIL ar_fresh_latency got %0d want 3", lat); end
    n_run++; if (bus1.out_addr !== '0 || bus1.out_data !== '0) begin
      n_fail++; $display("FAIL ar_fresh_word got %0d/%0d want 0/0", bus1.out_addr, bus1.out_data); end
  endtask

  task automatic test_rd_lat2();
    int            lat;
    int            words;
    logic          p_valid;
    logic [AW-1:0] exp_addr;
    run2 = 1'b1; bus2.out_ready = 1'b1; reset_n2 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (bus2.out_valid) begin lat = i; break; end
    end
    n_run++; if (lat != 7) begin n_fail++; $display("FAIL lat2_first_latency got %0d want 7", lat); end
    n_run++; if (bus2.out_addr !== '0 || bus2.out_data !== mem2[0]) begin
      n_fail++; $display("FAIL lat2_word0 got %0d/%0d want 0/%0d", bus2.out_addr, bus2.out_data, mem2[0]); end
    exp_addr = 5'd1; words = 1; p_valid = bus2.out_valid;
    for (int c = 0; c < 1500 && words < 33; c++) begin
      bus2.out_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
      if (bus2.out_valid && !p_valid) begin
        n_run++; if (bus2.out_addr !== exp_addr || bus2.out_data !== mem2[exp_addr]) begin
          n_fail++; $display("FAIL lat2_word got %0d/%0d want %0d/%0d", bus2.out_addr, bus2.out_data, exp_addr, mem2[exp_addr]); end
        exp_addr = exp_addr + 1'b1;
        words++;
      end
      p_valid = bus2.out_valid;
    end
    n_run++; if (words != 33) begin n_fail++; $display("FAIL lat2_word_count got %0d want 33", words); end
    run2 = 1'b0; bus2.out_ready = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem1[a] = DW'(a % 8);
      mem2[a] = DW'($urandom_range(0, 7));
    end
    test_reset();
    test_autoscan();
    test_backpressure();
    test_step();
    test_restart();
    test_async_reset();
    test_rd_lat2();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
